// File: rtl/idu_hazard_ctrl_pkg.sv
// idu_hazard_ctrl_pkg: shared types for the decode hazard controller
// Contents: hz_state_t FSM encoding, REG_ADDR_W, hz_dec_t decoded-instruction bundle, sat_inc helper.
package idu_hazard_ctrl_pkg;
   localparam int REG_ADDR_W = 4;
   typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} hz_state_t;
   typedef struct packed {
      logic                  valid;
      logic                  rs1;
      logic [REG_ADDR_W-1:0] rs1_addr;
      logic                  rs2;
      logic [REG_ADDR_W-1:0] rs2_addr;
      logic                  rd;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  load;
      logic                  div;
      logic                  is_exit;
   } hz_dec_t;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register pending-write bits for long-latency producers
// Ports: clk, rst (sync, active-high); set_en/set_addr mark a register pending;
// clr_en/clr_addr release it (set wins on the same index); rs1/rs2/rd_addr read
// ports return rs1_busy/rs2_busy/rd_busy; busy is the OR of all bits.
module hz_scoreboard
   import idu_hazard_ctrl_pkg::*;
#(
   parameter int NREG = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rd_busy,
   output logic                  busy
);
   logic [NREG-1:0] sb_q, sb_d;
   always_comb begin
      sb_d = sb_q;
      if (clr_en) sb_d[clr_addr] = 1'b0;
      if (set_en) sb_d[set_addr] = 1'b1;
   end
   always_ff @(posedge clk) sb_q <= rst ? '0 : sb_d;
   assign rs1_busy = sb_q[rs1_addr];
   assign rs2_busy = sb_q[rs2_addr];
   assign rd_busy  = sb_q[rd_addr];
   assign busy     = |sb_q;
endmodule

// File: rtl/idu_hazard_ctrl.sv
// idu_hazard_ctrl: decode-stage stall/flush scheduler with register scoreboard and exit halt sequencing
// Inputs: clk, rst (sync, active-high), dec_* decoded instruction fields, div_busy,
// wb_valid/wb_addr long-latency writeback, ld_done, exu_redirect.
// Outputs: pipe_stall, pipe_flush, halted, sb_busy, ld_cnt; with HAZARD_PERF_CNT_EN
// defined also perf_stall_cyc, perf_flush_cnt, perf_raw_cyc (32-bit saturating).
module idu_hazard_ctrl
   import idu_hazard_ctrl_pkg::*;
#(
   parameter int NREG         = 16,
   parameter int MAX_LD       = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           dec_valid,
   input  logic                           dec_rs1,
   input  logic [3:0]                     dec_rs1_addr,
   input  logic                           dec_rs2,
   input  logic [3:0]                     dec_rs2_addr,
   input  logic                           dec_rd,
   input  logic [3:0]                     dec_rd_addr,
   input  logic                           dec_load,
   input  logic                           dec_div,
   input  logic                           dec_exit,
   input  logic                           div_busy,
   input  logic                           wb_valid,
   input  logic [3:0]                     wb_addr,
   input  logic                           ld_done,
   input  logic                           exu_redirect,
   output logic                           pipe_stall,
   output logic                           pipe_flush,
   output logic                           halted,
   output logic                           sb_busy,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]                    perf_stall_cyc,
   output logic [31:0]                    perf_flush_cnt,
   output logic [31:0]                    perf_raw_cyc,
`endif
   output logic [$clog2(MAX_LD+1)-1:0]    ld_cnt
);
   localparam int LDW = $clog2(MAX_LD + 1);
   localparam int CW  = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES) : 1;
   // A single-cycle flush is fully covered by the combinational redirect term, so no FLUSH state is needed.
   localparam hz_state_t FLUSH_ST = hz_state_t'(FLUSH_CYCLES > 1 ? FLUSH : RUN);
   hz_dec_t        dec;
   hz_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [LDW-1:0] ld_cnt_q, ld_cnt_d;
   logic           rs1_busy, rs2_busy, rd_busy, raw, waw, ldfull, divhz, redir, issue;
   assign dec = '{valid: dec_valid, rs1: dec_rs1, rs1_addr: dec_rs1_addr, rs2: dec_rs2,
                  rs2_addr: dec_rs2_addr, rd: dec_rd, rd_addr: dec_rd_addr, load: dec_load,
                  div: dec_div, is_exit: dec_exit};
   hz_scoreboard #(.NREG(NREG)) u_sb (
      .clk,
      .rst,
      .set_en  (issue & dec.rd & (dec.load | dec.div)),
      .set_addr(dec.rd_addr),
      .clr_en  (wb_valid),
      .clr_addr(wb_addr),
      .rs1_addr(dec.rs1_addr),
      .rs2_addr(dec.rs2_addr),
      .rd_addr (dec.rd_addr),
      .rs1_busy,
      .rs2_busy,
      .rd_busy,
      .busy    (sb_busy)
   );
   always_ff @(posedge clk) begin
      state_q  <= rst ? RUN : state_d;
      cnt_q    <= rst ? '0 : cnt_d;
      ld_cnt_q <= rst ? '0 : ld_cnt_d;
   end
   always_comb begin
      state_d  = redir ? FLUSH_ST
               : state_q == FLUSH ? (cnt_q == '0 ? RUN : FLUSH)
               : issue & dec.is_exit ? DRAIN
               : state_q == DRAIN & ~sb_busy & ld_cnt_q == '0 ? HALT : state_q;
      cnt_d    = redir ? CW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0)
                       : cnt_q - CW'(state_q == FLUSH & cnt_q != '0);
      ld_cnt_d = ld_cnt_q + LDW'(issue & dec.load) - LDW'(ld_done & ld_cnt_q != '0);
   end
   // Hazards read the registered scoreboard, so a same-cycle writeback never releases a stall.
   always_comb begin
      raw        = dec.rs1 & rs1_busy | dec.rs2 & rs2_busy;
      waw        = dec.rd & rd_busy;
      ldfull     = dec.load & (ld_cnt_q == LDW'(MAX_LD));
      divhz      = dec.div & div_busy;
      redir      = ~rst & exu_redirect & (state_q != HALT);
      pipe_flush = redir | (~rst & state_q == FLUSH);
      pipe_stall = ~rst & ~pipe_flush & (state_q == DRAIN | state_q == HALT
                 | state_q == RUN & dec.valid & (raw | waw | ldfull | divhz));
      issue      = ~rst & dec.valid & ~pipe_stall & ~pipe_flush & state_q == RUN;
      halted     = state_q == HALT;
   end
   assign ld_cnt = ld_cnt_q;
   assert property (@(posedge clk) disable iff (rst) !(ld_done && ld_cnt_q == '0));
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q, stall_d, flush_q, flush_d, raw_q, raw_d;
   always_comb begin
      stall_d = state_q == HALT ? stall_q : sat_inc(stall_q, pipe_stall & state_q == RUN);
      flush_d = state_q == HALT ? flush_q : sat_inc(flush_q, redir);
      raw_d   = state_q == HALT ? raw_q : sat_inc(raw_q, pipe_stall & state_q == RUN & raw);
   end
   always_ff @(posedge clk) begin
      stall_q <= rst ? '0 : stall_d;
      flush_q <= rst ? '0 : flush_d;
      raw_q   <= rst ? '0 : raw_d;
   end
   assign perf_stall_cyc = stall_q;
   assign perf_flush_cnt = flush_q;
   assign perf_raw_cyc   = raw_q;
`endif
endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// tb_idu_hazard_ctrl: directed plus random scoreboard bench for idu_hazard_ctrl
module tb_idu_hazard_ctrl;
   localparam int MAX_LD = 4;
   localparam int FC     = 2;
   logic clk = 1'b0, rst;
   logic dec_valid, dec_rs1, dec_rs2, dec_rd, dec_load, dec_div, dec_exit;
   logic [3:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_addr;
   logic div_busy, wb_valid, ld_done, exu_redirect;
   logic pipe_stall, pipe_flush, halted, sb_busy;
   logic [2:0] ld_cnt;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_raw_cyc;
`endif
   always #5 clk = ~clk;
   idu_hazard_ctrl #(.NREG(16), .MAX_LD(MAX_LD), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs1_addr(dec_rs1_addr),
      .dec_rs2(dec_rs2), .dec_rs2_addr(dec_rs2_addr), .dec_rd(dec_rd), .dec_rd_addr(dec_rd_addr),
      .dec_load(dec_load), .dec_div(dec_div), .dec_exit(dec_exit), .div_busy(div_busy),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .ld_done(ld_done), .exu_redirect(exu_redirect),
      .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .halted(halted), .sb_busy(sb_busy),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_raw_cyc(perf_raw_cyc),
`endif
      .ld_cnt(ld_cnt));
   typedef struct {
      bit stall, flush, halted, busy, amb;
      int ld, ps, pf, pr;
   } exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0;
   // Reference model: pending-register set, outstanding loads, and a few mode flags.
   bit sb_m[16];
   int ld_m = 0, flush_left = 0, ps_m = 0, pf_m = 0, pr_m = 0, hc = 0;
   bit drain_m = 0, halt_m = 0;
   task automatic idle();
      {dec_valid, dec_rs1, dec_rs2, dec_rd, dec_load, dec_div, dec_exit} = '0;
      {dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_addr} = '0;
      {div_busy, wb_valid, ld_done, exu_redirect, rst} = '0;
   endtask
   task automatic model_step();
      exp_t e;
      bit any, redir, flush, raw, hz, stall, run_st, issue;
      int ld_pre;
      any = 0;
      for (int i = 0; i < 16; i++) any |= sb_m[i];
      e.halted = halt_m; e.busy = any; e.ld = ld_m; e.ps = ps_m; e.pf = pf_m; e.pr = pr_m;
      e.amb = halt_m && exu_redirect;
      if (rst) begin
         e.stall = 0; e.flush = 0; e.amb = 0;
         q.push_back(e);
         for (int i = 0; i < 16; i++) sb_m[i] = 0;
         ld_m = 0; flush_left = 0; drain_m = 0; halt_m = 0; ps_m = 0; pf_m = 0; pr_m = 0;
         return;
      end
      redir  = exu_redirect && !halt_m;
      flush  = redir || flush_left > 0;
      raw    = (dec_rs1 && sb_m[dec_rs1_addr]) || (dec_rs2 && sb_m[dec_rs2_addr]);
      hz     = raw || (dec_rd && sb_m[dec_rd_addr]) || (dec_load && ld_m == MAX_LD) || (dec_div && div_busy);
      run_st = !halt_m && !drain_m && flush_left == 0;
      stall  = !flush && (halt_m || drain_m || (dec_valid && hz));
      issue  = dec_valid && !stall && !flush && run_st;
      e.stall = stall; e.flush = flush;
      q.push_back(e);
      if (!halt_m) begin
         ps_m += int'(stall && run_st);
         pf_m += int'(redir);
         pr_m += int'(stall && run_st && raw);
      end
      if (redir) begin flush_left = FC - 1; drain_m = 0; end
      else if (flush_left > 0) flush_left--;
      else if (issue && dec_exit) drain_m = 1;
      else if (drain_m && !any && ld_m == 0) begin drain_m = 0; halt_m = 1; end
      if (wb_valid) sb_m[wb_addr] = 0;
      if (issue && dec_rd && (dec_load || dec_div)) sb_m[dec_rd_addr] = 1;
      ld_pre = ld_m;
      ld_m = ld_pre + int'(issue && dec_load) - int'(ld_done && ld_pre > 0);
   endtask
   task automatic go();
      model_step();
      @(negedge clk);
      idle();
   endtask
   task automatic rand_inputs();
      int s;
      dec_valid    = $urandom_range(0, 9) < 7;
      dec_rs1      = 1'($urandom_range(0, 1));
      dec_rs1_addr = 4'($urandom_range(0, 7));
      dec_rs2      = 1'($urandom_range(0, 1));
      dec_rs2_addr = 4'($urandom_range(0, 7));
      dec_rd       = $urandom_range(0, 9) < 7;
      dec_rd_addr  = 4'($urandom_range(0, 7));
      dec_load     = $urandom_range(0, 9) < 3;
      dec_div      = !dec_load && $urandom_range(0, 9) < 2;
      dec_exit     = $urandom_range(0, 99) < 2;
      div_busy     = $urandom_range(0, 9) < 3;
      wb_valid     = $urandom_range(0, 9) < 3;
      wb_addr      = 4'($urandom_range(0, 7));
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 7)
         for (int k = 0; k < 8; k++)
            if (sb_m[(s + k) % 8]) begin wb_addr = 4'((s + k) % 8); break; end
      ld_done      = ld_m > 0 && $urandom_range(0, 9) < 3;
      exu_redirect = $urandom_range(0, 99) < 5;
      hc           = halt_m ? hc + 1 : 0;
      rst          = $urandom_range(0, 199) == 0 || hc > 8;
   endtask
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", n, $time, act, exp);
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (!e.amb) begin
               chk("pipe_stall", 32'(pipe_stall), 32'(e.stall));
               chk("pipe_flush", 32'(pipe_flush), 32'(e.flush));
            end
            chk("halted", 32'(halted), 32'(e.halted));
            chk("sb_busy", 32'(sb_busy), 32'(e.busy));
            chk("ld_cnt", 32'(ld_cnt), e.ld);
`ifdef HAZARD_PERF_CNT_EN
            chk("perf_stall_cyc", perf_stall_cyc, e.ps);
            chk("perf_flush_cnt", perf_flush_cnt, e.pf);
            chk("perf_raw_cyc", perf_raw_cyc, e.pr);
`endif
         end
      end
   end
   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      rst = 1; go();
      rst = 1; go();
      // RAW on a pending load destination until writeback
      dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 3; go();
      for (int i = 0; i < 3; i++) begin dec_valid = 1; dec_rs1 = 1; dec_rs1_addr = 3; go(); end
      dec_valid = 1; dec_rs1 = 1; dec_rs1_addr = 3; wb_valid = 1; wb_addr = 3; ld_done = 1; go();
      dec_valid = 1; dec_rs1 = 1; dec_rs1_addr = 3; go();
      // Outstanding-load limit
      for (int i = 0; i < 6; i++) begin dec_valid = 1; dec_load = 1; go(); end
      dec_valid = 1; dec_load = 1; ld_done = 1; go();
      dec_valid = 1; dec_load = 1; go();
      for (int i = 0; i < 4; i++) begin ld_done = 1; go(); end
      // Redirect while stalled on RAW
      dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 2; go();
      dec_valid = 1; dec_rs2 = 1; dec_rs2_addr = 2; exu_redirect = 1; go();
      for (int i = 0; i < 3; i++) begin dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 7; go(); end
      wb_valid = 1; wb_addr = 2; ld_done = 1; go();
      ld_done = 1; wb_valid = 1; wb_addr = 7; go();
      // Exit drains, halts, ignores redirect
      dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 1; go();
      dec_valid = 1; dec_exit = 1; go();
      go(); go();
      ld_done = 1; wb_valid = 1; wb_addr = 1; go();
      go(); go();
      exu_redirect = 1; go();
      go();
      rst = 1; go();
      // Same-cycle set and clear of r5
      dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 5; wb_valid = 1; wb_addr = 5; go();
      dec_valid = 1; dec_rs1 = 1; dec_rs1_addr = 5; go();
      wb_valid = 1; wb_addr = 5; ld_done = 1; go();
      // Redirect during drain aborts the exit
      dec_valid = 1; dec_div = 1; dec_rd = 1; dec_rd_addr = 4; go();
      dec_valid = 1; dec_exit = 1; go();
      go();
      exu_redirect = 1; go();
      go(); go(); go();
      wb_valid = 1; wb_addr = 4; go();
      // Reset mid-drain
      dec_valid = 1; dec_load = 1; dec_rd = 1; dec_rd_addr = 6; go();
      dec_valid = 1; dec_exit = 1; go();
      go();
      rst = 1; go();
      go(); go();
      for (int n = 0; n < 4000; n++) begin rand_inputs(); go(); end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
